// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
//   state_e      : sequencer states (RUN, HALTED, STEP)
//   PC_INC       : sequential fetch increment in bytes
//   NBITS_DEF    : default PC / target width
//   RESET_PC_DEF : default PC loaded on reset
package pc_seq_pkg;

   localparam int unsigned NBITS_DEF    = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned PC_INC       = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      STEP   = 2'd2
   } state_e;

endpackage : pc_seq_pkg

// File: rtl/pc_target_sel.sv
// Combinational next-PC source select for the fetch stage.
// Priority: EX branch > ID JALR > ID jump > PC+4. ID redirects are dropped
// while stalled because the ID instruction is re-presented after the stall.
// Redirect targets are word-aligned by clearing bits [1:0].
// Ports:
//   i_pc          current PC
//   i_stall       hazard stall
//   i_pcSrc       branch taken (EX), i_br_tgt its target
//   i_jalr        JR/JALR (ID), i_rs its target
//   i_jump        J/JAL (ID), i_j_tgt its target
//   o_next_pc     selected next PC (aligned)
//   o_redirect    any redirect is being applied
//   o_branch      the applied redirect is the EX branch
//   o_misaligned  applied redirect target had bits [1:0] != 0
//   o_advance     PC register should load o_next_pc
module pc_target_sel
   import pc_seq_pkg::*;
#(
   parameter int unsigned NBITS = NBITS_DEF
) (
   input  logic [NBITS-1:0] i_pc,
   input  logic             i_stall,
   input  logic             i_pcSrc,
   input  logic [NBITS-1:0] i_br_tgt,
   input  logic             i_jalr,
   input  logic [NBITS-1:0] i_rs,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_j_tgt,
   output logic [NBITS-1:0] o_next_pc,
   output logic             o_redirect,
   output logic             o_branch,
   output logic             o_misaligned,
   output logic             o_advance
);

   logic             id_redir;
   logic [NBITS-1:0] raw_tgt;

   assign id_redir   = ~i_stall & (i_jalr | i_jump);
   assign o_branch   = i_pcSrc;
   assign o_redirect = i_pcSrc | id_redir;

   always_comb begin
      raw_tgt = i_j_tgt;
      if (i_pcSrc)     raw_tgt = i_br_tgt;
      else if (i_jalr) raw_tgt = i_rs;
   end

   assign o_misaligned = o_redirect & (|raw_tgt[1:0]);
   assign o_next_pc    = o_redirect ? {raw_tgt[NBITS-1:2], 2'b00}
                                    : i_pc + NBITS'(PC_INC);
   // A taken branch still moves the PC during a stall; it flushes the
   // stalled instructions anyway.
   assign o_advance    = o_redirect | ~i_stall;

endmodule : pc_target_sel

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: owns the PC register,
// applies the selected next-PC source, honours stall and halt/resume, and
// drives the IF/ID and ID/EX flush strobes.
// Optional feature macro: PC_SEQ_STEP_EN (single-step from HALTED).
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_stall               hazard stall, hold PC
//   i_halt, i_resume      enter / leave HALTED
//   i_pcSrc, i_SumadorBranch   EX branch taken + target
//   i_Jump, i_SumadorJump      ID jump + target
//   i_JALR, i_rs               ID register jump + target
//   i_step                single-step pulse (only with PC_SEQ_STEP_EN)
//   o_pc                  registered fetch address
//   o_fetch_en            instruction memory read enable
//   o_flush_if/o_flush_id flush strobes, valid in the redirect cycle
//   o_halted              sequencer is in HALTED
//   o_misaligned          sticky misaligned-redirect flag
//
// state  | meaning
// RUN    | normal fetch, redirects and stalls honoured
// HALTED | PC frozen, no fetch, all inputs but resume/step ignored
// STEP   | one fetch at the frozen PC, then back to HALTED
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned      NBITS    = NBITS_DEF,
   parameter logic [NBITS-1:0] RESET_PC = NBITS'(RESET_PC_DEF)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic             i_halt,
   input  logic             i_resume,
   input  logic             i_pcSrc,
   input  logic [NBITS-1:0] i_SumadorBranch,
   input  logic             i_Jump,
   input  logic [NBITS-1:0] i_SumadorJump,
   input  logic             i_JALR,
   input  logic [NBITS-1:0] i_rs,
   input  logic             i_step,
   output logic [NBITS-1:0] o_pc,
   output logic             o_fetch_en,
   output logic             o_flush_if,
   output logic             o_flush_id,
   output logic             o_halted,
   output logic             o_misaligned
);

`ifdef PC_SEQ_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [NBITS-1:0] pc_q, pc_d;
   logic             mis_q, mis_d;

   logic [NBITS-1:0] next_pc;
   logic             redirect, branch, misaligned, advance;
   logic             active, step_go;

   pc_target_sel #(.NBITS(NBITS)) u_sel (
      .i_pc         (pc_q),
      .i_stall      (i_stall),
      .i_pcSrc      (i_pcSrc),
      .i_br_tgt     (i_SumadorBranch),
      .i_jalr       (i_JALR),
      .i_rs         (i_rs),
      .i_jump       (i_Jump),
      .i_j_tgt      (i_SumadorJump),
      .o_next_pc    (next_pc),
      .o_redirect   (redirect),
      .o_branch     (branch),
      .o_misaligned (misaligned),
      .o_advance    (advance)
   );

   // Resume wins over step; a halt request alongside step keeps us halted.
   assign step_go = STEP_EN & i_step & ~i_resume & ~i_halt;
   assign active  = (state_q == RUN) || (state_q == STEP);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (i_halt) state_d = HALTED;
         HALTED: begin
            if (i_resume && !i_halt) state_d = RUN;
            else if (step_go)        state_d = STEP;
         end
         STEP:    state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_d  = (active && advance) ? next_pc : pc_q;
      mis_d = mis_q | (active & misaligned);
   end

   always_comb begin
      o_fetch_en = 1'b0;
      o_flush_if = 1'b0;
      o_flush_id = 1'b0;
      case (state_q)
         RUN: begin
            o_fetch_en = advance;
            o_flush_if = redirect;
            o_flush_id = branch;
         end
         STEP: begin
            o_fetch_en = 1'b1;
            o_flush_if = redirect;
            o_flush_id = branch;
         end
         default: ;
      endcase
   end

   assign o_pc         = pc_q;
   assign o_halted     = (state_q == HALTED);
   assign o_misaligned = mis_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected next-PC values are queued when
// a cycle's stimulus is applied and compared after the following edge.
module tb_pc_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_stall, i_halt, i_resume, i_pcSrc, i_Jump, i_JALR, i_step;
   logic [31:0] i_SumadorBranch, i_SumadorJump, i_rs;
   logic [31:0] o_pc;
   logic        o_fetch_en, o_flush_if, o_flush_id, o_halted, o_misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   pc_sequencer dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_stall         (i_stall),
      .i_halt          (i_halt),
      .i_resume        (i_resume),
      .i_pcSrc         (i_pcSrc),
      .i_SumadorBranch (i_SumadorBranch),
      .i_Jump          (i_Jump),
      .i_SumadorJump   (i_SumadorJump),
      .i_JALR          (i_JALR),
      .i_rs            (i_rs),
      .i_step          (i_step),
      .o_pc            (o_pc),
      .o_fetch_en      (o_fetch_en),
      .o_flush_if      (o_flush_if),
      .o_flush_id      (o_flush_id),
      .o_halted        (o_halted),
      .o_misaligned    (o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #20000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      i_stall = 0; i_halt = 0; i_resume = 0; i_pcSrc = 0; i_Jump = 0;
      i_JALR = 0; i_step = 0;
   endtask

   // Called just after a falling edge with inputs applied.
   task automatic cyc(input string tag, input logic [31:0] nxt,
                      input logic fi, input logic fd, input logic fe);
      logic [31:0] e;
      #1;
      chk({tag, "_flush_if"}, {31'd0, o_flush_if}, {31'd0, fi});
      chk({tag, "_flush_id"}, {31'd0, o_flush_id}, {31'd0, fd});
      chk({tag, "_fetch_en"}, {31'd0, o_fetch_en}, {31'd0, fe});
      exp_q.push_back(nxt);
      @(posedge i_clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_pc"}, o_pc, e);
      end
      @(negedge i_clk);
   endtask

   initial begin
      idle_inputs();
      i_SumadorBranch = 0; i_SumadorJump = 0; i_rs = 0;
      i_rst_n = 0;
      #12;
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_halted", {31'd0, o_halted}, 32'd0);
      chk("rst_mis", {31'd0, o_misaligned}, 32'd0);
      chk("rst_flush", {30'd0, o_flush_if, o_flush_id}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1;

      cyc("seq0", 32'h4, 0, 0, 1);
      cyc("seq1", 32'h8, 0, 0, 1);
      cyc("seq2", 32'hC, 0, 0, 1);
      cyc("seq3", 32'h10, 0, 0, 1);

      i_halt = 1;
      cyc("halt", 32'h14, 0, 0, 1);
      chk("halted_set", {31'd0, o_halted}, 32'd1);
      i_halt = 0;
      i_SumadorBranch = 32'h300;
      for (int k = 0; k < 5; k++) begin
         i_pcSrc = k[0];
         i_stall = k[1];
         cyc("frozen", 32'h14, 0, 0, 0);
      end
      idle_inputs();
      i_halt = 1; i_resume = 1;
      cyc("halt_resume", 32'h14, 0, 0, 0);
      chk("still_halted", {31'd0, o_halted}, 32'd1);
      idle_inputs();
      i_resume = 1;
      cyc("resume", 32'h14, 0, 0, 0);
      chk("halted_clr", {31'd0, o_halted}, 32'd0);
      idle_inputs();
      cyc("fetch_frozen", 32'h18, 0, 0, 1);

      i_pcSrc = 1; i_SumadorBranch = 32'h100;
      i_Jump = 1;  i_SumadorJump = 32'h200;
      cyc("br_over_jump", 32'h100, 1, 1, 1);
      idle_inputs();
      i_stall = 1; i_JALR = 1; i_rs = 32'h40;
      cyc("stall_jalr", 32'h100, 0, 0, 0);
      i_pcSrc = 1; i_SumadorBranch = 32'h80;
      cyc("stall_br", 32'h80, 1, 1, 1);
      idle_inputs();
      i_JALR = 1; i_rs = 32'h44; i_Jump = 1; i_SumadorJump = 32'h600;
      cyc("jalr_over_jump", 32'h44, 1, 0, 1);
      chk("mis_clean", {31'd0, o_misaligned}, 32'd0);
      idle_inputs();
      i_Jump = 1; i_SumadorJump = 32'h203;
      cyc("jump_mis", 32'h200, 1, 0, 1);
      chk("mis_set", {31'd0, o_misaligned}, 32'd1);
      i_SumadorJump = 32'h400;
      cyc("jump_ok", 32'h400, 1, 0, 1);
      chk("mis_sticky", {31'd0, o_misaligned}, 32'd1);
      idle_inputs();
      i_pcSrc = 1; i_SumadorBranch = 32'h501;
      cyc("br_mis", 32'h500, 1, 1, 1);

      idle_inputs();
      i_Jump = 1; i_SumadorJump = 32'hFFFF_FFFC;
      cyc("jump_top", 32'hFFFF_FFFC, 1, 0, 1);
      idle_inputs();
      cyc("wrap", 32'h0, 0, 0, 1);

      i_halt = 1; i_pcSrc = 1; i_SumadorBranch = 32'h700;
      cyc("halt_with_br", 32'h700, 1, 1, 1);
      idle_inputs();
      chk("halted2", {31'd0, o_halted}, 32'd1);
      #2;
      i_rst_n = 0;
      #1;
      chk("async_pc", o_pc, 32'h0);
      chk("async_halted", {31'd0, o_halted}, 32'd0);
      chk("async_mis", {31'd0, o_misaligned}, 32'd0);
      exp_q.delete();
      @(negedge i_clk);
      i_rst_n = 1;
      cyc("post_rst", 32'h4, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pc_sequencer
